exec_flag_stage: RTL

Execute-to-writeback pipeline stage that sits directly downstream of the 16-bit ALU. It registers the ALU result and destination and owns the architectural NZCV flag register, which is updated from the ALU `cc` output. It also resolves conditional branches against that flag register. It hands one entry per cycle to writeback over a valid/ready handshake.

---
 rtl/exec_flag_stage_pkg.sv | 42 ++++
 rtl/exec_flag_stage_if.sv | 43 ++++
 rtl/exec_cond_eval.sv | 45 ++++
 rtl/exec_flag_stage.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/exec_flag_stage_pkg.sv
// Shared definitions for the execute-to-writeback flag stage: widths, condition
// codes, flag bit positions and the registered payload layout.
package exec_flag_stage_pkg;

    localparam int EFS_DATA_W  = 16;
    localparam int EFS_REG_AW  = 3;
    localparam int EFS_COND_W  = 4;
    localparam int EFS_FLAGS_W = 4;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_MI = 4'd3;
    localparam logic [3:0] COND_PL = 4'd4;
    localparam logic [3:0] COND_CS = 4'd5;
    localparam logic [3:0] COND_CC = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_GT = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_LE = 4'd12;
    localparam logic [3:0] COND_HI = 4'd13;
    localparam logic [3:0] COND_LS = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [EFS_DATA_W-1:0] result;
        logic                  we;
        logic [EFS_REG_AW-1:0] dst;
        logic                  taken;
        logic [EFS_DATA_W-1:0] target;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

endpackage

// File: rtl/exec_flag_stage_if.sv
// Handshake bundle between the ALU side, the flag stage and writeback.
// master = the surrounding pipeline, slave = the stage itself.
interface exec_flag_stage_if
    import exec_flag_stage_pkg::*;
#(
    parameter int DATA_W = EFS_DATA_W,
    parameter int REG_AW = EFS_REG_AW
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [3:0]        in_cc;
    logic              in_set_cc;
    logic              in_we;
    logic [REG_AW-1:0] in_dst;
    logic              in_branch;
    logic [3:0]        in_cond;
    logic [DATA_W-1:0] in_target;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_we;
    logic [REG_AW-1:0] out_dst;
    logic              out_taken;
    logic [DATA_W-1:0] out_target;
    logic [3:0]        flags;

    modport master (
        output in_valid, in_result, in_cc, in_set_cc, in_we, in_dst,
               in_branch, in_cond, in_target, out_ready,
        input  in_ready, out_valid, out_result, out_we, out_dst,
               out_taken, out_target, flags
    );

    modport slave (
        input  in_valid, in_result, in_cc, in_set_cc, in_we, in_dst,
               in_branch, in_cond, in_target, out_ready,
        output in_ready, out_valid, out_result, out_we, out_dst,
               out_taken, out_target, flags
    );

endinterface

// File: rtl/exec_cond_eval.sv
// Combinational branch-condition evaluator: maps the NZCV flags and a 4-bit
// condition code to a taken decision.
module exec_cond_eval
    import exec_flag_stage_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = flags[FLAG_N];
    assign z_s = flags[FLAG_Z];
    assign c_s = flags[FLAG_C];
    assign v_s = flags[FLAG_V];

    // Condition decode
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = z_s;
            COND_NE: taken = ~z_s;
            COND_MI: taken = n_s;
            COND_PL: taken = ~n_s;
            COND_CS: taken = c_s;
            COND_CC: taken = ~c_s;
            COND_VS: taken = v_s;
            COND_VC: taken = ~v_s;
            COND_GT: taken = ~z_s & (n_s == v_s);
            COND_GE: taken = (n_s == v_s);
            COND_LT: taken = (n_s != v_s);
            COND_LE: taken = z_s | (n_s != v_s);
            COND_HI: taken = c_s & ~z_s;
            COND_LS: taken = ~c_s | z_s;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_flag_stage.sv
// Execute-to-writeback stage: registers the ALU payload, owns the NZCV flags and
// resolves branches. Define EXEC_FLAG_STAGE_SKID_EN for a registered-ready skid entry.
module exec_flag_stage
    import exec_flag_stage_pkg::*;
#(
    parameter int DATA_W = EFS_DATA_W,
    parameter int REG_AW = EFS_REG_AW
)(
    input  logic              clk,
    input  logic              reset,
    exec_flag_stage_if.slave  bus
);

    logic              cond_taken_s;
    logic              accept_s;
    logic              consume_s;
    logic              in_ready_s;
    payload_t          in_entry_s;
    logic [3:0]        flags_r;
    logic [3:0]        flags_next_s;
    payload_t          out_r;
    payload_t          out_next_s;
    logic              out_valid_r;
    logic              out_valid_next_s;
    logic [DATA_W-1:0] out_result_s;
    logic [DATA_W-1:0] out_target_s;
    logic [REG_AW-1:0] out_dst_s;

    // Branches see the flags as they stand before this edge's update.
    exec_cond_eval u_cond_eval (
        .flags (flags_r),
        .cond  (bus.in_cond),
        .taken (cond_taken_s)
    );

    assign accept_s  = bus.in_valid & in_ready_s;
    assign consume_s = out_valid_r & bus.out_ready;

    // Assemble the entry captured on acceptance; a flag-setting op is never taken.
    always_comb begin
        in_entry_s        = '0;
        in_entry_s.result = bus.in_result;
        in_entry_s.we     = bus.in_we;
        in_entry_s.dst    = bus.in_dst;
        in_entry_s.taken  = bus.in_branch & ~bus.in_set_cc & cond_taken_s;
        in_entry_s.target = bus.in_target;
    end

    // Flags change only in the acceptance cycle of a flag-setting entry.
    always_comb begin
        if (accept_s && bus.in_set_cc) begin
            flags_next_s = bus.in_cc;
        end else begin
            flags_next_s = flags_r;
        end
    end

`ifdef EXEC_FLAG_STAGE_SKID_EN
    payload_t skid_r;
    payload_t skid_next_s;
    logic     skid_valid_r;
    logic     skid_valid_next_s;
    logic     in_ready_r;

    assign in_ready_s = in_ready_r;

    // Output/skid steering: skid drains first, new entries park in skid on stall.
    always_comb begin
        out_next_s        = out_r;
        out_valid_next_s  = out_valid_r;
        skid_next_s       = skid_r;
        skid_valid_next_s = skid_valid_r;
        if (!out_valid_r || consume_s) begin
            if (skid_valid_r) begin
                out_next_s        = skid_r;
                out_valid_next_s  = 1'b1;
                skid_valid_next_s = 1'b0;
            end else if (accept_s) begin
                out_next_s       = in_entry_s;
                out_valid_next_s = 1'b1;
            end else begin
                out_valid_next_s = 1'b0;
            end
        end else if (accept_s) begin
            skid_next_s       = in_entry_s;
            skid_valid_next_s = 1'b1;
        end else begin
            skid_valid_next_s = skid_valid_r;
        end
    end

    // Skid storage and the registered ready derived from skid occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_r       <= '0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            skid_r       <= skid_next_s;
            skid_valid_r <= skid_valid_next_s;
            in_ready_r   <= ~skid_valid_next_s;
        end
    end
`else
    assign in_ready_s = ~out_valid_r | bus.out_ready;

    // Single output register: refill on accept, empty on consume, otherwise hold.
    always_comb begin
        out_next_s = out_r;
        if (accept_s) begin
            out_next_s       = in_entry_s;
            out_valid_next_s = 1'b1;
        end else if (consume_s) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end
    end
`endif

    // Architectural flags and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r     <= 4'b0000;
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            flags_r     <= flags_next_s;
            out_r       <= out_next_s;
            out_valid_r <= out_valid_next_s;
        end
    end

    assign out_result_s   = out_r.result;
    assign out_target_s   = out_r.target;
    assign out_dst_s      = out_r.dst;

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = out_result_s;
    assign bus.out_we     = out_r.we;
    assign bus.out_dst    = out_dst_s;
    assign bus.out_taken  = out_r.taken;
    assign bus.out_target = out_target_s;
    assign bus.flags      = flags_r;

endmodule
